// File: rtl/mdio_phy_responder_if.sv
`timescale 1ns/1ps
// MDIO pin pair, link status and BMCR-derived control levels of the on-chip PHY model.
interface mdio_phy_responder_if;
    logic       mdc;
    logic       mdio_in;
    logic       mdio_out;
    logic       mdio_z;
    logic       link_up;
    logic       loopback_en;
    logic [1:0] speed_sel;
    logic       an_en;
    logic       fulldpx_en;
    logic       wr_pulse;

    modport master (
        output mdc, mdio_in, link_up,
        input  mdio_out, mdio_z, loopback_en, speed_sel, an_en, fulldpx_en, wr_pulse
    );

    modport slave (
        input  mdc, mdio_in, link_up,
        output mdio_out, mdio_z, loopback_en, speed_sel, an_en, fulldpx_en, wr_pulse
    );
endinterface

// File: rtl/mdio_phy_responder.sv
`timescale 1ns/1ps
// Clause 22 MDIO responder: decodes oversampled MDC/MDIO frames, serves BMCR/BMSR/PHYID
// and drives read data on MDIO after each detected MDC fall.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int          PREAMBLE_LEN = 32,
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1622,
    parameter logic [15:0] BMCR_RST     = 16'h1140
) (
    input  logic                 clk_125M,
    input  logic                 rst_n,
    mdio_phy_responder_if.slave  phy_bus
);
    localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
    localparam int CNT_W = (PRE_W > 5) ? PRE_W : 5;
    localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(PREAMBLE_LEN);
    localparam logic [CNT_W-1:0] C1  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C4  = CNT_W'(4);
    localparam logic [CNT_W-1:0] C15 = CNT_W'(15);
    localparam logic [CNT_W-1:0] C16 = CNT_W'(16);
    localparam logic [15:0] BMSR_BASE = 16'h7809;

    typedef enum logic [2:0] {S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA} state_t;

    logic r_mdc_meta, r_mdc_sync, r_mdc_dly, r_mdio_meta, r_mdio_sync;
    logic w_mdc_rise, w_mdc_fall;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [4:0]       r_addr, w_addr_next, w_addr5;
    logic [15:0]      r_sh, w_sh_next, w_wdata, w_rd_val;
    logic             r_rd, w_rd_next;
    logic             r_mdio_out, w_mdio_out_next;
    logic             r_mdio_z, w_mdio_z_next;
    logic [15:0]      r_bmcr, w_bmcr_next;
    logic             r_wr_pulse, w_wr_pulse_next;
    logic             r_link, w_rd_done;

    always_ff @(posedge clk_125M or negedge rst_n) begin
        if (!rst_n) begin
            r_mdc_meta  <= 1'b0;
            r_mdc_sync  <= 1'b0;
            r_mdc_dly   <= 1'b0;
            r_mdio_meta <= 1'b0;
            r_mdio_sync <= 1'b0;
        end else begin
            r_mdc_meta  <= phy_bus.mdc;
            r_mdc_sync  <= r_mdc_meta;
            r_mdc_dly   <= r_mdc_sync;
            r_mdio_meta <= phy_bus.mdio_in;
            r_mdio_sync <= r_mdio_meta;
        end
    end

    assign w_mdc_rise = r_mdc_sync & ~r_mdc_dly;
    assign w_mdc_fall = ~r_mdc_sync & r_mdc_dly;
    assign w_addr5    = {r_addr[3:0], r_mdio_sync};
    assign w_wdata    = {r_sh[14:0], r_mdio_sync};

    // Read value is chosen from the register address completed by the current sample.
    always_comb begin
        case (w_addr5)
            5'd0:    w_rd_val = {1'b0, r_bmcr[14:0]};
            5'd1:    w_rd_val = {BMSR_BASE[15:3], r_link, BMSR_BASE[1:0]};
            5'd2:    w_rd_val = PHY_ID1;
            5'd3:    w_rd_val = PHY_ID2;
            default: w_rd_val = 16'h0000;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_addr_next     = r_addr;
        w_sh_next       = r_sh;
        w_rd_next       = r_rd;
        w_mdio_out_next = r_mdio_out;
        w_mdio_z_next   = r_mdio_z;
        w_bmcr_next     = r_bmcr;
        w_wr_pulse_next = 1'b0;
        w_rd_done       = 1'b0;
        if (w_mdc_rise) begin
            case (r_state)
                S_IDLE: begin
                    if (r_mdio_sync) begin
                        if (r_cnt < PRE_MAX) w_cnt_next = r_cnt + C1;
                    end else begin
                        w_cnt_next = '0;
                        if (r_cnt >= PRE_MAX) w_state_next = S_ST;
                    end
                end
                S_ST: begin
                    w_cnt_next   = '0;
                    w_state_next = r_mdio_sync ? S_OP : S_IDLE;
                end
                S_OP: begin
                    w_addr_next = w_addr5;
                    if (r_cnt == '0) begin
                        w_cnt_next = C1;
                    end else begin
                        w_cnt_next = '0;
                        case ({r_addr[0], r_mdio_sync})
                            2'b10:   begin w_rd_next = 1'b1; w_state_next = S_PHYAD; end
                            2'b01:   begin w_rd_next = 1'b0; w_state_next = S_PHYAD; end
                            default: w_state_next = S_IDLE;
                        endcase
                    end
                end
                S_PHYAD: begin
                    w_addr_next = w_addr5;
                    if (r_cnt == C4) begin
                        w_cnt_next   = '0;
                        w_state_next = (w_addr5 == PHY_ADDR) ? S_REGAD : S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + C1;
                    end
                end
                S_REGAD: begin
                    w_addr_next = w_addr5;
                    if (r_cnt == C4) begin
                        w_cnt_next   = '0;
                        w_state_next = S_TA;
                        if (r_rd) w_sh_next = w_rd_val;
                    end else begin
                        w_cnt_next = r_cnt + C1;
                    end
                end
                S_TA: begin
                    if (r_cnt == C1) begin
                        w_cnt_next   = '0;
                        w_state_next = S_DATA;
                    end else begin
                        w_cnt_next = r_cnt + C1;
                    end
                end
                S_DATA: begin
                    if (r_rd) begin
                        w_cnt_next = r_cnt + C1;
                    end else begin
                        w_sh_next = w_wdata;
                        if (r_cnt == C15) begin
                            w_cnt_next   = '0;
                            w_state_next = S_IDLE;
                            // Only BMCR is writable; bits 5:0 are hardwired zero.
                            if (r_addr == 5'd0) begin
                                w_bmcr_next     = w_wdata[15] ? BMCR_RST : {1'b0, w_wdata[14:6], 6'b0};
                                w_wr_pulse_next = 1'b1;
                            end
                        end else begin
                            w_cnt_next = r_cnt + C1;
                        end
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end else if (w_mdc_fall && r_rd) begin
            if (r_state == S_TA && r_cnt == C1) begin
                w_mdio_z_next   = 1'b0;
                w_mdio_out_next = 1'b0;
            end else if (r_state == S_DATA) begin
                if (r_cnt == C16) begin
                    w_mdio_z_next   = 1'b1;
                    w_mdio_out_next = 1'b0;
                    w_state_next    = S_IDLE;
                    w_cnt_next      = '0;
                    w_rd_done       = (r_addr == 5'd1);
                end else begin
                    w_mdio_out_next = r_sh[15];
                    w_sh_next       = {r_sh[14:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_125M or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_sh       <= '0;
            r_rd       <= 1'b0;
            r_mdio_out <= 1'b0;
            r_mdio_z   <= 1'b1;
            r_bmcr     <= BMCR_RST;
            r_wr_pulse <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_addr     <= w_addr_next;
            r_sh       <= w_sh_next;
            r_rd       <= w_rd_next;
            r_mdio_out <= w_mdio_out_next;
            r_mdio_z   <= w_mdio_z_next;
            r_bmcr     <= w_bmcr_next;
            r_wr_pulse <= w_wr_pulse_next;
        end
    end

    // Latched-low link: a low level always wins over a completing BMSR read.
    always_ff @(posedge clk_125M or negedge rst_n) begin
        if (!rst_n) begin
            r_link <= 1'b0;
        end else if (!phy_bus.link_up) begin
            r_link <= 1'b0;
        end else if (w_rd_done) begin
            r_link <= 1'b1;
        end
    end

    assign phy_bus.mdio_out    = r_mdio_out;
    assign phy_bus.mdio_z      = r_mdio_z;
    assign phy_bus.loopback_en = r_bmcr[14];
    assign phy_bus.speed_sel   = {r_bmcr[6], r_bmcr[13]};
    assign phy_bus.an_en       = r_bmcr[12];
    assign phy_bus.fulldpx_en  = r_bmcr[8];
    assign phy_bus.wr_pulse    = r_wr_pulse;
endmodule

// File: tb/tb_mdio_phy_responder.sv
`timescale 1ns/1ps
// Bench for mdio_phy_responder: bit-banged MDIO initiator with a queue of expected read values.
module tb_mdio_phy_responder;
    localparam int HALF = 80;

    logic clk_125M = 1'b0;
    logic rst_n    = 1'b0;
    always #4 clk_125M = ~clk_125M;

    mdio_phy_responder_if bus();

    mdio_phy_responder #(
        .PHY_ADDR(5'd1), .PREAMBLE_LEN(32), .PHY_ID1(16'h0022),
        .PHY_ID2(16'h1622), .BMCR_RST(16'h1140)
    ) dut (
        .clk_125M (clk_125M),
        .rst_n    (rst_n),
        .phy_bus  (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [4:0]  w_ctrl;
    assign w_ctrl = {bus.loopback_en, bus.speed_sel, bus.an_en, bus.fulldpx_en};

    int   wr_hi_clks = 0;
    int   wr_rises   = 0;
    logic wr_prev    = 1'b0;
    always @(negedge clk_125M) begin
        if (bus.wr_pulse === 1'b1) wr_hi_clks <= wr_hi_clks + 1;
        if (bus.wr_pulse === 1'b1 && wr_prev !== 1'b1) wr_rises <= wr_rises + 1;
        wr_prev <= bus.wr_pulse;
    end

    // Bad-frame table: short preamble, illegal opcode, foreign PHYAD, write to read-only reg 1.
    int          t_pre[6] = '{31, 31, 32, 32, 32, 32};
    logic [1:0]  t_op[6]  = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b01};
    logic [4:0]  t_phy[6] = '{5'd1, 5'd1, 5'd1, 5'd2, 5'd2, 5'd1};
    logic [4:0]  t_reg[6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1};
    logic [15:0] t_dat[6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};

    task automatic clk_bit(input logic b, output logic z_s, output logic d_s);
        bus.mdio_in = b;
        #(HALF);
        z_s = bus.mdio_z;
        d_s = bus.mdio_out;
        bus.mdc = 1'b1;
        #(HALF);
        bus.mdc = 1'b0;
    endtask

    task automatic send_frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                              input logic [4:0] regad, input logic [15:0] wdata, input int stop_at,
                              output logic [15:0] rdata, output logic [17:0] zvec,
                              output logic early_low, output logic z_post, output logic ta2_out);
        logic [13:0] hdr;
        logic z_s, d_s, b, rd;
        hdr = {2'b01, op, phy, regad};
        rd  = (op == 2'b10);
        rdata = '0; zvec = '1; early_low = 1'b0; z_post = 1'b1; ta2_out = 1'b1;
        for (int i = 0; i < pre_len; i++) begin
            clk_bit(1'b1, z_s, d_s);
            if (z_s !== 1'b1) early_low = 1'b1;
        end
        for (int i = 13; i >= 0; i--) begin
            clk_bit(hdr[i], z_s, d_s);
            if (z_s !== 1'b1) early_low = 1'b1;
        end
        for (int i = 0; i < stop_at; i++) begin
            if (rd) b = 1'b0;
            else if (i < 2) b = (i == 0);
            else b = wdata[17 - i];
            clk_bit(b, z_s, d_s);
            zvec[17 - i] = z_s;
            if (i == 1) ta2_out = d_s;
            if (i >= 2) rdata[17 - i] = d_s;
        end
        if (stop_at == 18) begin
            #(HALF);
            z_post = bus.mdio_z;
        end
    endtask

    task automatic test_reset();
        bus.mdc = 1'b0; bus.mdio_in = 1'b1; bus.link_up = 1'b1; rst_n = 1'b0;
        #16;
        n_checks++; if (bus.mdio_z !== 1'b1) begin n_fail++; $display("FAIL reset_mdio_z: got %b want 1", bus.mdio_z); end
        n_checks++; if (bus.mdio_out !== 1'b0) begin n_fail++; $display("FAIL reset_mdio_out: got %b want 0", bus.mdio_out); end
        n_checks++; if (bus.wr_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wr_pulse: got %b want 0", bus.wr_pulse); end
        n_checks++; if (w_ctrl !== 5'b01011) begin n_fail++; $display("FAIL reset_ctrl: got %b want 01011", w_ctrl); end
        #16; rst_n = 1'b1; #32;
        n_checks++; if (bus.mdio_z !== 1'b1) begin n_fail++; $display("FAIL post_reset_mdio_z: got %b want 1", bus.mdio_z); end
        n_checks++; if (w_ctrl !== 5'b01011) begin n_fail++; $display("FAIL post_reset_ctrl: got %b want 01011", w_ctrl); end
        $display("test_reset done: ctrl=%b z=%b", w_ctrl, bus.mdio_z);
    endtask

    task automatic test_read_id();
        logic [15:0] rd, exp; logic [17:0] zv; logic el, zp, t2;
        exp_q.push_back(16'h0022);
        send_frame(32, 2'b10, 5'd1, 5'd2, 16'h0000, 18, rd, zv, el, zp, t2);
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL read_id1_data: got %h want %h", rd, exp); end
        n_checks++; if (zv !== 18'h20000) begin n_fail++; $display("FAIL read_id1_zwin: got %b want %b", zv, 18'h20000); end
        n_checks++; if (el !== 1'b0) begin n_fail++; $display("FAIL read_id1_hdr_z: drove during header"); end
        n_checks++; if (zp !== 1'b1) begin n_fail++; $display("FAIL read_id1_release: z=%b want 1", zp); end
        n_checks++; if (t2 !== 1'b0) begin n_fail++; $display("FAIL read_id1_ta2: out=%b want 0", t2); end
        $display("read reg2: data=%h zwin=%b", rd, zv);
    endtask

    task automatic test_write_bmcr();
        logic [15:0] rd, exp; logic [17:0] zv; logic el, zp, t2; int w0, h0;
        w0 = wr_rises; h0 = wr_hi_clks;
        send_frame(32, 2'b01, 5'd1, 5'd0, 16'h4100, 18, rd, zv, el, zp, t2);
        n_checks++; if (w_ctrl !== 5'b10001) begin n_fail++; $display("FAIL wr4100_ctrl: got %b want 10001", w_ctrl); end
        n_checks++; if (wr_rises - w0 !== 1) begin n_fail++; $display("FAIL wr4100_pulses: got %0d want 1", wr_rises - w0); end
        n_checks++; if (wr_hi_clks - h0 !== 1) begin n_fail++; $display("FAIL wr4100_width: got %0d want 1", wr_hi_clks - h0); end
        exp_q.push_back(16'h4100);
        send_frame(32, 2'b10, 5'd1, 5'd0, 16'h0000, 18, rd, zv, el, zp, t2);
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rd_bmcr_4100: got %h want %h", rd, exp); end
        $display("write 4100: ctrl=%b readback=%h", w_ctrl, rd);
    endtask

    task automatic test_soft_reset();
        logic [15:0] rd, exp; logic [17:0] zv; logic el, zp, t2; int w0;
        w0 = wr_rises;
        send_frame(32, 2'b01, 5'd1, 5'd0, 16'h8000, 18, rd, zv, el, zp, t2);
        n_checks++; if (w_ctrl !== 5'b01011) begin n_fail++; $display("FAIL soft_rst_ctrl: got %b want 01011", w_ctrl); end
        n_checks++; if (wr_rises - w0 !== 1) begin n_fail++; $display("FAIL soft_rst_pulses: got %0d want 1", wr_rises - w0); end
        exp_q.push_back(16'h1140);
        send_frame(32, 2'b10, 5'd1, 5'd0, 16'h0000, 18, rd, zv, el, zp, t2);
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rd_bmcr_soft: got %h want %h", rd, exp); end
        $display("write 8000: ctrl=%b readback=%h", w_ctrl, rd);
    endtask

    task automatic test_link();
        logic [15:0] rd, exp; logic [17:0] zv; logic el, zp, t2;
        bus.link_up = 1'b0; #80; bus.link_up = 1'b1; #80;
        exp_q.push_back(16'h7809);
        exp_q.push_back(16'h780D);
        for (int k = 0; k < 2; k++) begin
            send_frame(32, 2'b10, 5'd1, 5'd1, 16'h0000, 18, rd, zv, el, zp, t2);
            exp = exp_q.pop_front();
            n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL bmsr_read%0d: got %h want %h", k, rd, exp); end
            $display("bmsr read %0d: data=%h", k, rd);
        end
    endtask

    task automatic test_bad_frames();
        logic [15:0] rd, exp; logic [17:0] zv; logic el, zp, t2; int w0;
        for (int k = 0; k < 6; k++) begin
            w0 = wr_rises;
            send_frame(t_pre[k], t_op[k], t_phy[k], t_reg[k], t_dat[k], 18, rd, zv, el, zp, t2);
            n_checks++; if ((el | ~&zv | ~zp) !== 1'b0) begin n_fail++; $display("FAIL bad%0d_z: mdio driven zwin=%b", k, zv); end
            n_checks++; if (wr_rises - w0 !== 0) begin n_fail++; $display("FAIL bad%0d_wr: got %0d pulses want 0", k, wr_rises - w0); end
            n_checks++; if (w_ctrl !== 5'b01011) begin n_fail++; $display("FAIL bad%0d_ctrl: got %b want 01011", k, w_ctrl); end
            $display("bad frame %0d: ctrl=%b zwin=%b", k, w_ctrl, zv);
        end
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h1140);
        send_frame(32, 2'b10, 5'd1, 5'd4, 16'h0000, 18, rd, zv, el, zp, t2);
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rd_reg4: got %h want %h", rd, exp); end
        send_frame(32, 2'b10, 5'd1, 5'd0, 16'h0000, 18, rd, zv, el, zp, t2);
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rd_bmcr_after_bad: got %h want %h", rd, exp); end
        $display("reg4 / bmcr after bad frames: bmcr=%h", rd);
    endtask

    task automatic test_midframe_reset();
        logic [15:0] rd, exp; logic [17:0] zv; logic el, zp, t2; int w0;
        w0 = wr_rises;
        send_frame(32, 2'b01, 5'd1, 5'd0, 16'h013F, 18, rd, zv, el, zp, t2);
        n_checks++; if (wr_rises - w0 !== 1) begin n_fail++; $display("FAIL wr013f_pulses: got %0d want 1", wr_rises - w0); end
        n_checks++; if (w_ctrl !== 5'b00001) begin n_fail++; $display("FAIL wr013f_ctrl: got %b want 00001", w_ctrl); end
        exp_q.push_back(16'h0100);
        send_frame(32, 2'b10, 5'd1, 5'd0, 16'h0000, 18, rd, zv, el, zp, t2);
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rd_bmcr_ro_bits: got %h want %h", rd, exp); end
        // Stop after D9, then assert reset while D8 is on the line.
        send_frame(32, 2'b10, 5'd1, 5'd0, 16'h0000, 9, rd, zv, el, zp, t2);
        bus.mdio_in = 1'b0;
        #(HALF);
        n_checks++; if (bus.mdio_z !== 1'b0) begin n_fail++; $display("FAIL abort_driving_d8: z=%b want 0", bus.mdio_z); end
        rst_n = 1'b0;
        #2;
        n_checks++; if (bus.mdio_z !== 1'b1) begin n_fail++; $display("FAIL abort_release: z=%b want 1", bus.mdio_z); end
        n_checks++; if (w_ctrl !== 5'b01011) begin n_fail++; $display("FAIL abort_ctrl: got %b want 01011", w_ctrl); end
        #6; #32; rst_n = 1'b1; #32;
        exp_q.push_back(16'h1622);
        send_frame(32, 2'b10, 5'd1, 5'd3, 16'h0000, 18, rd, zv, el, zp, t2);
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL rd_id2_after_abort: got %h want %h", rd, exp); end
        n_checks++; if (zv !== 18'h20000 || zp !== 1'b1) begin n_fail++; $display("FAIL rd_id2_zwin: got %b post=%b", zv, zp); end
        $display("after mid-frame reset: reg3=%h", rd);
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_write_bmcr();
        test_soft_reset();
        test_link();
        test_bad_frames();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
